// File: rtl/dmem_responder_pkg.sv
// Shared defines for the memory-stage slice: responder states, wait counter
// width and the ALU control codes used by the execute stage.
package dmem_responder_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef logic [WAIT_CNT_W-1:0] waitCnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } aluCtrl_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: one port, per-byte write enables, registered
// read that only updates on a read access. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (we == 4'b0000) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM in front of dmem_array, with range
// check, stall generation and error flag.
//
//   state | meaning
//   IDLE  | no request in flight; mem_en starts one
//   WAIT  | counting down inserted wait states
//   RESP  | access committed on entry; rdata/err valid, stall released
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam waitCnt_t WAIT_LOAD = (WAIT_CYCLES > 0) ? waitCnt_t'(WAIT_CYCLES - 1) : '0;

  dmemState_t  state;
  waitCnt_t    waitCnt;
  logic        rdataZero;
  logic        commit;
  logic        outOfRange;
  logic        isRead;
  logic        arrayEn;
  logic [31:0] arrayRdata;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^mem_addr[1:0];

  // Depth is a power of two, so any set bit above the word index is out of range.
  assign outOfRange = |mem_addr[31:ADDR_W+2];
  assign isRead     = (mem_we == 4'b0000);

  always_comb begin
    commit = 1'b0;
    case (state)
      IDLE:    commit = mem_en && (WAIT_CYCLES == 0);
      WAIT:    commit = (waitCnt == '0);
      default: commit = 1'b0;
    endcase
  end

  assign arrayEn   = commit && !rst && !outOfRange;
  assign mem_stall = !rst && (((state == IDLE) && mem_en) || (state == WAIT));

  // The array read register has no reset, so a flag forces the zero value
  // after reset and after an out-of-range access.
  assign mem_rdata = rdataZero ? 32'h0 : arrayRdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      rdataZero <= 1'b1;
      mem_err   <= 1'b0;
    end else begin
      mem_err <= commit && outOfRange;
      if (commit && (outOfRange || isRead)) begin
        rdataZero <= outOfRange;
      end
      case (state)
        IDLE: begin
          if (mem_en) begin
            if (WAIT_CYCLES > 0) begin
              state   <= WAIT;
              waitCnt <= WAIT_LOAD;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) uArray (
    .clk   (clk),
    .en    (arrayEn),
    .we    (mem_we),
    .addr  (mem_addr[ADDR_W+1:2]),
    .wdata (mem_wdata),
    .rdata (arrayRdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 3 wait states.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       en;
  logic [2:0]       stall;
  logic [2:0]       err;
  logic [2:0][3:0]  we;
  logic [2:0][31:0] addr;
  logic [2:0][31:0] wdata;
  logic [2:0][31:0] rdata;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  always @(posedge clk) cycle++;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .mem_en(en[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_stall(stall[0]), .mem_err(err[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst[1]), .mem_en(en[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_stall(stall[1]), .mem_err(err[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst[2]), .mem_en(en[2]), .mem_we(we[2]), .mem_addr(addr[2]),
    .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_stall(stall[2]), .mem_err(err[2]));

  // Called away from the rising edge; returns 1 time unit after the falling
  // edge of the RESP cycle with the request already withdrawn.
  task automatic access(input int d, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] dat, output int stallCnt,
                        output logic [31:0] rd, output logic er, output int respCycle);
    int guard;
    en[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dat;
    stallCnt = 0;
    guard = 0;
    #1;
    while (guard < 40) begin
      if (stall[d]) stallCnt++;
      else if (stallCnt > 0) break;
      guard++;
      @(negedge clk); #1;
    end
    rd = rdata[d];
    er = err[d];
    respCycle = cycle;
    en[d] = 1'b0; we[d] = 4'h0;
    tests++;
    if (guard >= 40) begin
      fails++;
      $display("FAIL access_timeout dut%0d addr=%h: no RESP within 40 cycles", d, a);
    end
  endtask

  task automatic test_reset();
    rst = 3'b111; en = 3'b111; we = '0; addr = '0; wdata = '0;
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if (stall !== 3'b000) begin
      fails++; $display("FAIL reset_stall got=%b exp=000", stall);
    end
    tests++;
    if (rdata[1] !== 32'h0 || rdata[2] !== 32'h0) begin
      fails++; $display("FAIL reset_rdata got=%h/%h exp=0", rdata[1], rdata[2]);
    end
    tests++;
    if (err !== 3'b000) begin
      fails++; $display("FAIL reset_err got=%b exp=000", err);
    end
    rst = 3'b000; en = 3'b000;
    @(negedge clk); #1;
    tests++;
    if (stall !== 3'b000) begin
      fails++; $display("FAIL idle_stall got=%b exp=000", stall);
    end
  endtask

  task automatic test_write_read();
    int sc, rc; logic [31:0] rd; logic er;
    access(1, 4'hF, 32'h10, 32'hDEADBEEF, sc, rd, er, rc);
    tests++;
    if (sc !== 2) begin fails++; $display("FAIL wr_stall got=%0d exp=2", sc); end
    tests++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      fails++; $display("FAIL wr_rdata_err got=%h/%b exp=0/0", rd, er);
    end
    access(1, 4'h0, 32'h10, 32'h0, sc, rd, er, rc);
    tests++;
    if (sc !== 2) begin fails++; $display("FAIL rd_stall got=%0d exp=2", sc); end
    tests++;
    if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_lane();
    int sc, rc; logic [31:0] rd; logic er;
    access(1, 4'hF, 32'h20, 32'h11223344, sc, rd, er, rc);
    access(1, 4'b0010, 32'h20, 32'h0000AB00, sc, rd, er, rc);
    tests++;
    if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lane_wr_keeps_rdata got=%h exp=deadbeef", rd); end
    access(1, 4'h0, 32'h20, 32'h0, sc, rd, er, rc);
    tests++;
    if (rd !== 32'h1122AB44) begin fails++; $display("FAIL lane_b1 got=%h exp=1122ab44", rd); end
    access(1, 4'b1001, 32'h22, 32'hCC0000DD, sc, rd, er, rc);
    access(1, 4'h0, 32'h20, 32'h0, sc, rd, er, rc);
    tests++;
    if (rd !== 32'hCC22ABDD) begin fails++; $display("FAIL lane_b03 got=%h exp=cc22abdd", rd); end
  endtask

  task automatic test_zero_wait();
    int sc, rcA, rcB; logic [31:0] rd; logic er;
    access(0, 4'hF, 32'h0, 32'h01010101, sc, rd, er, rcA);
    access(0, 4'hF, 32'h4, 32'h02020202, sc, rd, er, rcA);
    access(0, 4'h0, 32'h0, 32'h0, sc, rd, er, rcA);
    tests++;
    if (sc !== 1 || rd !== 32'h01010101) begin
      fails++; $display("FAIL zw_read0 stall=%0d rdata=%h exp=1/01010101", sc, rd);
    end
    access(0, 4'h0, 32'h4, 32'h0, sc, rd, er, rcB);
    tests++;
    if (sc !== 1 || rd !== 32'h02020202) begin
      fails++; $display("FAIL zw_read4 stall=%0d rdata=%h exp=1/02020202", sc, rd);
    end
    tests++;
    if (rcB - rcA !== 2) begin
      fails++; $display("FAIL zw_alternate resp_gap=%0d exp=2", rcB - rcA);
    end
  endtask

  task automatic test_out_of_range();
    int sc, rc; logic [31:0] rd; logic er;
    access(1, 4'hF, 32'h0, 32'hA5A5A5A5, sc, rd, er, rc);
    access(1, 4'h0, 32'h10, 32'h0, sc, rd, er, rc);
    access(1, 4'hF, 32'h1000, 32'h0BADF00D, sc, rd, er, rc);
    tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL oor_write err=%b rdata=%h exp=1/0", er, rd);
    end
    @(negedge clk); #1;
    tests++;
    if (err[1] !== 1'b0) begin fails++; $display("FAIL oor_write_pulse err=%b exp=0", err[1]); end
    access(1, 4'h0, 32'h1000, 32'h0, sc, rd, er, rc);
    tests++;
    if (er !== 1'b1 || rd !== 32'h0 || sc !== 2) begin
      fails++; $display("FAIL oor_read err=%b rdata=%h stall=%0d exp=1/0/2", er, rd, sc);
    end
    @(negedge clk); #1;
    tests++;
    if (err[1] !== 1'b0) begin fails++; $display("FAIL oor_read_pulse err=%b exp=0", err[1]); end
    access(1, 4'h0, 32'h0, 32'h0, sc, rd, er, rc);
    tests++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      fails++; $display("FAIL oor_no_alias rdata=%h err=%b exp=a5a5a5a5/0", rd, er);
    end
  endtask

  task automatic test_reset_mid_op();
    int sc, rc; logic [31:0] rd; logic er;
    access(2, 4'hF, 32'h8, 32'h55AA55AA, sc, rd, er, rc);
    tests++;
    if (sc !== 4) begin fails++; $display("FAIL w3_stall got=%0d exp=4", sc); end
    access(2, 4'h0, 32'h8, 32'h0, sc, rd, er, rc);
    tests++;
    if (rd !== 32'h55AA55AA) begin fails++; $display("FAIL w3_read got=%h exp=55aa55aa", rd); end
    @(negedge clk);
    en[2] = 1'b1; we[2] = 4'hF; addr[2] = 32'h8; wdata[2] = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    tests++;
    if (stall[2] !== 1'b0) begin fails++; $display("FAIL rst_mid_stall got=%b exp=0", stall[2]); end
    @(negedge clk); #1;
    tests++;
    if (rdata[2] !== 32'h0 || err[2] !== 1'b0) begin
      fails++; $display("FAIL rst_mid_out rdata=%h err=%b exp=0/0", rdata[2], err[2]);
    end
    rst[2] = 1'b0; en[2] = 1'b0; we[2] = 4'h0;
    #1;
    tests++;
    if (stall[2] !== 1'b0) begin fails++; $display("FAIL rst_mid_idle stall=%b exp=0", stall[2]); end
    access(2, 4'h0, 32'h8, 32'h0, sc, rd, er, rc);
    tests++;
    if (rd !== 32'h55AA55AA || sc !== 4) begin
      fails++; $display("FAIL rst_mid_readback rdata=%h stall=%0d exp=55aa55aa/4", rd, sc);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lane();
    test_zero_wait();
    test_out_of_range();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
